ha_array_accum_8x8: RTL and testbench
=====================================

// Module: ha_array_accum_8x8
// PURPOSE
//  Final-summation stage downstream of the approximate 8x8 unsigned multiplier's half-adder row array.
//  - Accepts the four partial rows (ha_array_N_b / ha_array_N_t) in a single valid/ready handshake.
//  - Sums the rows serially, one row per clock, into an unsigned product.
//  - Presents the product on a valid/ready output port.
//  - Area-lean replacement for a full combinational carry-save tree.
// PARAMETERS
//  OUT_W     16  product width; internal accumulator is OUT_W+1 bits
//  SATURATE  1   1: clamp to 2^OUT_W-1 and set sat; 0: truncate modulo 2^OUT_W, sat still flags overflow
// PORTS
//  clk            in   1  single clock, rising edge
//  rst_n          in   1  synchronous, active-low reset
//  in_valid       in   1  row bundle valid
//  in_ready       out  1  stage can accept a bundle
//  ha_array_0_b   in   7  row0 carry bits;  ha_array_0_t in 9 row0 sum bits
//  ha_array_1_b   in   7  row1 carry bits;  ha_array_1_t in 9 row1 sum bits
//  ha_array_2_b   in   7  row2 carry bits;  ha_array_2_t in 9 row2 sum bits
//  ha_array_3_b   in   7  row3 carry bits;  ha_array_3_t in 9 row3 sum bits
//  out_valid      out  1  product valid
//  out_ready      in   1  consumer accepts product
//  product        out  OUT_W  summed (approximate) product
//  sat            out  1  accumulator exceeded 2^OUT_W-1 for this product
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain (clk). Reset is synchronous and active-low (rst_n).
//  - Reset values: in_ready=0 during reset, 1 on the first cycle after release. out_valid=0, product=0, sat=0.
//  - FSM=IDLE, row counter=0, accumulator=0.
//  Row arithmetic
//  - Row r value V_r = t + (b << 2): t[k] weighs 2^k, b[k] weighs 2^(k+2).
//  - V_r is 10 bits, max 1019.
//  - Row r contributes V_r << (2*r).
//  - Sum max = 1019*85 = 86615, which needs 17 bits; the accumulator is OUT_W+1 bits.
//  FSM
//  - IDLE: in_ready=1. On in_valid&&in_ready, capture all 8 row inputs, clear acc and cnt, go to ACC.
//  - ACC: in_ready=0. Each cycle acc += V_cnt << 2*cnt, cnt++.
//  - ACC -> DONE after the cnt=3 add.
//  - DONE: out_valid=1. product and sat are registered and stable while out_valid&&!out_ready.
//  - DONE with out_ready=1: pop the result.
//    - If in_valid=1 in the same cycle, capture the new bundle and go to ACC.
//    - Otherwise go to IDLE.
//  - DONE: in_ready = out_ready.
//  Latency and throughput
//  - The accept edge starts ACC. out_valid rises 5 edges after accept (4 ACC cycles, then DONE).
//  - Back-to-back throughput is 1 product per 5 cycles.
//  Saturation
//  - sat=acc[OUT_W]. With SATURATE=1, product=all ones when sat=1; otherwise product=acc[OUT_W-1:0].
//  Boundaries
//  - in_valid while busy (ACC) is ignored; upstream must hold it under valid/ready rules.
//  - out_ready while out_valid=0 has no effect.
//  - rst_n low mid-ACC or mid-DONE: the bundle is discarded, no out_valid is produced, and all outputs return to reset values next edge.
//  - Captured inputs are frozen; input changes after accept do not affect the result.
// STRUCTURE
//  - Package ha_array_pkg:
//    - NUM_ROWS=4, ROW_B_W=7, ROW_T_W=9, ROW_SHIFT=2, ROW_VAL_W=10.
//    - typedef ha_row_t {b,t}.
//    - FSM enum {IDLE,ACC,DONE}.
//  - Sub-module ha_row_weight (combinational): ha_row_t -> ROW_VAL_W value t+(b<<2).
//    - One instance, muxed by cnt.
//  - Top: capture regs, 2-bit cnt, 17-bit acc, FSM, output regs.
// TESTING
//  1. All rows zero, accept -> out_valid 5 edges later, product=0, sat=0.
//  2. Only ha_array_0_t=9'h001 -> product=1. Only ha_array_3_b[6]=1 -> product=16384 (2^(6+2+6)).
//  3. All b=7'h7F and all t=9'h1FF -> acc=86615.
//     - SATURATE=1: product=16'hFFFF, sat=1.
//     - SATURATE=0: product=16'h5257, sat=1.
//  4. Backpressure: out_ready=0 for 6 cycles -> out_valid, product and sat stay constant, in_ready=0. Release pops in 1 cycle.
//  5. Back-to-back: in_valid held with two bundles (products 1 and 16384), out_ready=1.
//     - Second bundle is captured on the DONE/pop edge.
//     - Products appear in order, 5 cycles apart.
//  6. rst_n low for 1 cycle in the 2nd ACC cycle -> no out_valid for that bundle; in_ready=1 the cycle after release.

Source files
------------

// File: rtl/ha_array_pkg.sv
// ----------------------------------------------------------------------------
// ha_array_pkg
// Shared constants and types for the half-adder row array summation stage.
//   NUM_ROWS   : number of partial rows delivered per bundle
//   ROW_B_W    : carry-bit width of one row (b)
//   ROW_T_W    : sum-bit width of one row (t)
//   ROW_SHIFT  : weight offset of b relative to t (b[k] weighs 2^(k+2))
//   ROW_VAL_W  : width of one row's combined value t + (b << 2)
//   ha_row_t   : one captured row {b, t}
//   state_e    : summation FSM states
// ----------------------------------------------------------------------------
package ha_array_pkg;

    localparam int NUM_ROWS  = 4;
    localparam int ROW_B_W   = 7;
    localparam int ROW_T_W   = 9;
    localparam int ROW_SHIFT = 2;
    localparam int ROW_VAL_W = 10;

    typedef struct packed {
        logic [ROW_B_W-1:0] b;
        logic [ROW_T_W-1:0] t;
    } ha_row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ha_row_weight.sv
// ----------------------------------------------------------------------------
// ha_row_weight
// Combinational weighting of one half-adder row: value = t + (b << 2).
// Maximum value is 511 + 127*4 = 1019, which fits in ROW_VAL_W bits.
// Ports:
//   row   in   ha_row_t          captured row {b, t}
//   value out  ROW_VAL_W bits    weighted row value
// ----------------------------------------------------------------------------
module ha_row_weight
    import ha_array_pkg::*;
(
    input  ha_row_t                row,
    output logic [ROW_VAL_W-1:0]   value
);

    assign value = ROW_VAL_W'(row.t) + (ROW_VAL_W'(row.b) << ROW_SHIFT);

endmodule

// File: rtl/ha_array_accum_8x8.sv
// ----------------------------------------------------------------------------
// ha_array_accum_8x8
// Serial final-summation stage for the approximate 8x8 multiplier. Accepts
// four partial rows in one valid/ready handshake, adds one row per clock
// (row r weighted by 4^r) into an OUT_W+1 bit accumulator, then holds the
// product on a valid/ready output until it is popped.
// Parameters:
//   OUT_W     product width (accumulator is OUT_W+1 bits)
//   SATURATE  1: clamp product to all ones on overflow; 0: truncate
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid / in_ready            input bundle handshake
//   ha_array_N_b / ha_array_N_t    row N carry (7b) and sum (9b) bits, N=0..3
//   out_valid / out_ready          product handshake
//   product                        OUT_W-bit summed product
//   sat                            accumulator overflowed OUT_W bits
// ----------------------------------------------------------------------------
module ha_array_accum_8x8
    import ha_array_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       ha_array_0_b,
    input  logic [8:0]       ha_array_0_t,
    input  logic [6:0]       ha_array_1_b,
    input  logic [8:0]       ha_array_1_t,
    input  logic [6:0]       ha_array_2_b,
    input  logic [8:0]       ha_array_2_t,
    input  logic [6:0]       ha_array_3_b,
    input  logic [8:0]       ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             sat
);

    localparam int ACC_W = OUT_W + 1;

    state_e                 state_q, state_d;
    logic [1:0]             cnt_q;
    logic [ACC_W-1:0]       acc_q;
    logic [ACC_W-1:0]       acc_sum;
    logic [OUT_W-1:0]       product_q;
    logic                   sat_q;
    ha_row_t                rows_q [NUM_ROWS];
    logic [ROW_VAL_W-1:0]   row_val;
    logic                   capture;
    logic                   in_ready_c;
    logic                   out_valid_c;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                // A new bundle may only enter on the same edge the result leaves.
                in_ready_c  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        capture = 1'b1;
                        state_d = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready must read 0 while reset is asserted, even though the state
    // register only settles to IDLE on the reset edge.
    assign in_ready  = rst_n & in_ready_c;
    assign out_valid = out_valid_c;
    assign product   = product_q;
    assign sat       = sat_q;

    // ------------------------------------------------------------------
    // Row capture
    // ------------------------------------------------------------------
    // NOTE: the captured rows are pure data and are always written on the
    // accept edge before the accumulator reads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            rows_q[0] <= '{b: ha_array_0_b, t: ha_array_0_t};
            rows_q[1] <= '{b: ha_array_1_b, t: ha_array_1_t};
            rows_q[2] <= '{b: ha_array_2_b, t: ha_array_2_t};
            rows_q[3] <= '{b: ha_array_3_b, t: ha_array_3_t};
        end
    end

    // Single weighting unit shared by all rows, selected by the row counter.
    ha_row_weight u_row_weight (
        .row   (rows_q[cnt_q]),
        .value (row_val)
    );

    // Row r lands at bit position 2*r.
    assign acc_sum = acc_q + (ACC_W'(row_val) << {cnt_q, 1'b0});

    // ------------------------------------------------------------------
    // Accumulator, row counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            sat_q     <= 1'b0;
        end else if (capture) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == ACC) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
                sat_q     <= acc_sum[OUT_W];
                product_q <= (SATURATE != 0 && acc_sum[OUT_W]) ? {OUT_W{1'b1}}
                                                               : acc_sum[OUT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ha_array_accum_8x8.sv
// ----------------------------------------------------------------------------
// tb_ha_array_accum_8x8
// Drives a saturating and a truncating instance with identical stimulus and
// compares both against an arithmetic model of the row summation.
// ----------------------------------------------------------------------------
module tb_ha_array_accum_8x8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  b_v [4];
    logic [8:0]  t_v [4];

    logic        in_ready,   out_valid,   sat;
    logic [15:0] product;
    logic        in_ready_t, out_valid_t, sat_t;
    logic [15:0] product_t;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ha_array_accum_8x8 #(.OUT_W(16), .SATURATE(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (b_v[0]),
        .ha_array_0_t (t_v[0]),
        .ha_array_1_b (b_v[1]),
        .ha_array_1_t (t_v[1]),
        .ha_array_2_b (b_v[2]),
        .ha_array_2_t (t_v[2]),
        .ha_array_3_b (b_v[3]),
        .ha_array_3_t (t_v[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .sat          (sat)
    );

    ha_array_accum_8x8 #(.OUT_W(16), .SATURATE(0)) dut_trunc (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready_t),
        .ha_array_0_b (b_v[0]),
        .ha_array_0_t (t_v[0]),
        .ha_array_1_b (b_v[1]),
        .ha_array_1_t (t_v[1]),
        .ha_array_2_b (b_v[2]),
        .ha_array_2_t (t_v[2]),
        .ha_array_3_b (b_v[3]),
        .ha_array_3_t (t_v[3]),
        .out_valid    (out_valid_t),
        .out_ready    (out_ready),
        .product      (product_t),
        .sat          (sat_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact product of the bundle: sum over rows of (t + 4*b) * 4^r.
    function automatic int unsigned model_sum();
        int unsigned s = 0;
        for (int r = 0; r < 4; r++) begin
            s += (int'(t_v[r]) + 4 * int'(b_v[r])) * (4 ** r);
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rows();
        for (int r = 0; r < 4; r++) begin
            b_v[r] = '0;
            t_v[r] = '0;
        end
    endtask

    task automatic randomize_rows();
        for (int r = 0; r < 4; r++) begin
            b_v[r] = 7'($urandom);
            t_v[r] = 9'($urandom);
        end
    endtask

    task automatic expect_result(input string tag, input int unsigned s);
        logic        exp_sat;
        logic [15:0] exp_clamp;
        logic [15:0] exp_trunc;
        exp_sat   = (s > 32'd65535);
        exp_trunc = s[15:0];
        exp_clamp = exp_sat ? 16'hFFFF : exp_trunc;
        check({tag, ":product"},   product,   exp_clamp);
        check({tag, ":sat"},       sat,       exp_sat);
        check({tag, ":product_t"}, product_t, exp_trunc);
        check({tag, ":sat_t"},     sat_t,     exp_sat);
        check({tag, ":valid_t"},   out_valid_t, 1);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check({tag, ":ready"}, in_ready, 1);
    endtask

    // One bundle through the stage with 'hold' cycles of output backpressure.
    // The accept edge counts as the first edge; out_valid rises on the fifth.
    task automatic run_one(input string tag, input int hold);
        int unsigned s;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        wait_ready(tag);
        s = model_sum();
        step();
        in_valid = 1'b0;
        randomize_rows();
        check({tag, ":busy"}, in_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("%s:valid_e%0d", tag, i + 1), out_valid, (i == 4));
        end
        expect_result(tag, s);
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, ":hold_valid"}, out_valid, 1);
            check({tag, ":hold_ready"}, in_ready, 0);
            expect_result({tag, ":hold"}, s);
        end
        out_ready = 1'b1;
        #1;
        check({tag, ":pop_ready"}, in_ready, 1);
        step();
        check({tag, ":popped"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear_rows();

        // Reset state
        step();
        step();
        check("rst:in_ready",  in_ready,  0);
        check("rst:out_valid", out_valid, 0);
        check("rst:product",   product,   0);
        check("rst:sat",       sat,       0);
        rst_n = 1'b1;
        #1;
        check("rst:released_ready", in_ready, 1);

        // All rows zero
        clear_rows();
        run_one("zero", 0);

        // Single LSB in row 0 sum bits
        clear_rows();
        t_v[0] = 9'h001;
        run_one("t0_lsb", 1);

        // Top carry bit of row 3: 2^(6+2+6)
        clear_rows();
        b_v[3] = 7'h40;
        run_one("b3_msb", 0);

        // Every bit set: 86615 overflows 16 bits; held under backpressure
        for (int r = 0; r < 4; r++) begin
            b_v[r] = 7'h7F;
            t_v[r] = 9'h1FF;
        end
        run_one("all_ones", 6);

        // Random bundles with random backpressure
        for (int n = 0; n < 20; n++) begin
            randomize_rows();
            run_one($sformatf("rand%0d", n), int'($urandom_range(0, 3)));
        end

        // Back-to-back: second bundle enters on the pop edge of the first
        out_ready = 1'b1;
        clear_rows();
        t_v[0]   = 9'h001;
        in_valid = 1'b1;
        wait_ready("b2b");
        step();
        clear_rows();
        b_v[3] = 7'h40;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("b2b:a_valid_e%0d", i + 1), out_valid, (i == 4));
        end
        expect_result("b2b:a", 32'd1);
        check("b2b:a_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        randomize_rows();
        check("b2b:a_popped", out_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("b2b:b_valid_e%0d", i + 1), out_valid, (i == 4));
        end
        expect_result("b2b:b", 32'd16384);
        step();
        check("b2b:b_popped", out_valid, 0);
        check("b2b:idle_ready", in_ready, 1);
        out_ready = 1'b0;

        // Reset during the second ACC cycle discards the bundle
        randomize_rows();
        in_valid = 1'b1;
        wait_ready("midrst");
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("midrst:in_ready",  in_ready,  0);
        check("midrst:out_valid", out_valid, 0);
        check("midrst:product",   product,   0);
        check("midrst:sat",       sat,       0);
        rst_n = 1'b1;
        #1;
        check("midrst:released_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen |= out_valid | out_valid_t;
        end
        check("midrst:no_valid", seen, 0);

        // Stage still works after the mid-flight reset
        randomize_rows();
        run_one("post_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
